// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg
// Shared types and constants for the MEM/WB pipeline register.
//   - WB control bit positions (RegWrite, MemToReg)
//   - default-width payload struct
//   - occupancy state encoding, where bit 0 = main valid and bit 1 = skid valid
package mem_wb_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int WB_CTRL_W_DEF  = 2;

  localparam int WB_REGWRITE_BIT = 0;
  localparam int WB_MEMTOREG_BIT = 1;

  typedef struct packed {
    logic [DATA_W_DEF-1:0]     alu_result;
    logic [DATA_W_DEF-1:0]     read_data;
    logic [REG_ADDR_W_DEF-1:0] write_reg;
    logic [WB_CTRL_W_DEF-1:0]  wb_ctrl;
  } mem_wb_payload_t;

  // Encoding is {skid_v, main_v}, so each bit is directly a valid flag.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } mem_wb_state_e;

endpackage

// File: rtl/mem_wb_sat_cnt.sv
// mem_wb_sat_cnt
// Saturating up-counter that sticks at all-ones.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset; clears the count
//   inc_i  - increment enable for this cycle
//   cnt_o  - current count
module mem_wb_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// mem_wb_pipe_reg
// MEM/WB pipeline register with a valid/ready handshake and a 2-entry skid
// buffer. The main entry drives the outputs; the skid entry absorbs one beat
// when WB stalls, so in_ready is a pure register (no path from out_ready).
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   flush                  - synchronous kill of both entries (highest priority)
//   in_valid / in_ready    - MEM-side handshake (in_ready registered)
//   *_in                   - MEM payload: ALU result, load data, dest reg, WB ctrl
//   out_valid / out_ready  - WB-side handshake
//   *_out                  - registered payload from the main entry
//   fwd_valid/reg/data     - write-back-qualified forwarding tap (main entry only)
// Optional build macro MEM_WB_PERF_EN adds stall_cnt and bubble_cnt (CNT_W wide).
//
// state | meaning
// EMPTY | no beat held, outputs invalid
// ONE   | main entry holds a beat, skid empty
// FULL  | main and skid both hold beats, in_ready low
module mem_wb_pipe_reg
  import mem_wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int WB_CTRL_W  = 2
`ifdef MEM_WB_PERF_EN
  ,
  parameter int CNT_W      = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [DATA_W-1:0]     read_data_in,
  input  logic [REG_ADDR_W-1:0] write_reg_in,
  input  logic [WB_CTRL_W-1:0]  wb_ctrl_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     alu_result_out,
  output logic [DATA_W-1:0]     read_data_out,
  output logic [REG_ADDR_W-1:0] write_reg_out,
  output logic [WB_CTRL_W-1:0]  wb_ctrl_out,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_reg,
  output logic [DATA_W-1:0]     fwd_data
`ifdef MEM_WB_PERF_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      bubble_cnt
`endif
);

  localparam int PW = 2*DATA_W + REG_ADDR_W + WB_CTRL_W;

  mem_wb_state_e state_q;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;
  logic          in_ready_q;

  logic [PW-1:0] in_pay;
  logic          accept;
  logic          drain;

  assign in_pay = {alu_result_in, read_data_in, write_reg_in, wb_ctrl_in};
  assign accept = in_valid & in_ready_q;
  assign drain  = state_q[0] & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      // Payload is left in place; only the valid bits are dropped.
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_q  <= in_pay;
            state_q <= ONE;
          end
        end
        ONE: begin
          case ({drain, accept})
            2'b11: main_q <= in_pay;
            2'b10: state_q <= EMPTY;
            2'b01: begin
              skid_q     <= in_pay;
              state_q    <= FULL;
              in_ready_q <= 1'b0;
            end
            default: ;
          endcase
        end
        FULL: begin
          // in_ready is low here, so only a drain can move the state.
          if (drain) begin
            main_q     <= skid_q;
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = state_q[0];
  assign {alu_result_out, read_data_out, write_reg_out, wb_ctrl_out} = main_q;

  assign fwd_valid = out_valid & wb_ctrl_out[WB_REGWRITE_BIT] & (write_reg_out != '0);
  assign fwd_reg   = write_reg_out;
  assign fwd_data  = wb_ctrl_out[WB_MEMTOREG_BIT] ? read_data_out : alu_result_out;

`ifdef MEM_WB_PERF_EN
  mem_wb_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (out_valid & ~out_ready),
    .cnt_o (stall_cnt)
  );

  mem_wb_sat_cnt #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (~out_valid),
    .cnt_o (bubble_cnt)
  );
`endif

endmodule

// File: doc/mem_wb_pipe_reg.md
Name: mem_wb_pipe_reg

Overview:
Parametrised MEM/WB pipeline register with a valid/ready handshake and a 2-entry skid buffer, so back-pressure from WB never forms a combinational ready path into MEM. Carries ALU result, load data, destination register and WB control. Adds flush, a write-back-qualified forwarding tap, and reset.
- Sits between the MEM stage outputs and the WB mux / register-file write port.

Parameters:
DATA_W, 32, width of ALU result and load data
REG_ADDR_W, 5, destination register index width
WB_CTRL_W, 2, WB control width; bit 0 = RegWrite, bit 1 = MemToReg
CNT_W, 16, perf counter width (only with the optional feature)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all held entries
in_valid  in  1  MEM presents a beat
in_ready  out  1  register can accept a beat; registered, no combinational path from out_ready
alu_result_in  in  DATA_W  ALU result
read_data_in  in  DATA_W  load data
write_reg_in  in  REG_ADDR_W  destination register
wb_ctrl_in  in  WB_CTRL_W  WB control
out_valid  out  1  WB beat valid
out_ready  in  1  WB consumes the beat
alu_result_out  out  DATA_W  registered payload
read_data_out  out  DATA_W  registered payload
write_reg_out  out  REG_ADDR_W  registered payload
wb_ctrl_out  out  WB_CTRL_W  registered payload
fwd_valid  out  1  out_valid & wb_ctrl_out[0] & (write_reg_out != 0)
fwd_reg  out  REG_ADDR_W  equals write_reg_out
fwd_data  out  DATA_W  read_data_out if wb_ctrl_out[1], else alu_result_out

Behaviour:
- Reset (async, rst_n low): out_valid=0, skid valid=0, in_ready=1, all payload outputs 0, counters 0. Released synchronously into normal operation.
- Storage: main entry (drives outputs) and skid entry. State {main_v, skid_v}: EMPTY {0,0}, ONE {1,0}, FULL {1,1}. {0,1} is unreachable.
- in_ready = !skid_v, registered. Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- EMPTY: on accept, load main; go to ONE. Latency is 1 cycle, input to out_valid.
- ONE, drain and accept: main <= input; stay ONE.
- ONE, drain and no accept: go to EMPTY.
- ONE, accept and no drain: skid <= input; go to FULL; in_ready drops the next cycle.
- ONE, neither: hold.
- FULL (in_ready=0, so no accept):
  - on drain, main <= skid; go to ONE.
  - otherwise hold.
- Ordering is strictly FIFO. No beat is dropped or duplicated unless flushed.
- Payload holds while out_valid & !out_ready. Payload registers are not cleared on drain; only the valid bits are.
- flush=1: main_v=0 and skid_v=0 next cycle; an accept in the same cycle is discarded. flush has priority over every other transition. in_ready=1 the next cycle.
- fwd_* outputs are combinational from the main entry only; the skid entry is never forwarded.
- in_valid=0 with payload toggling causes no state change.

Optional Feature:
MEM_WB_PERF_EN
- Defined: adds outputs stall_cnt [CNT_W] and bubble_cnt [CNT_W].
  - stall_cnt increments each cycle out_valid & !out_ready.
  - bubble_cnt increments each cycle !out_valid.
  - Both saturate at all-ones, reset to 0 on rst_n, and are unaffected by flush.
- Undefined: these ports and registers do not exist. Core behaviour is identical in both builds.

Decomposition:
- Package mem_wb_pkg:
  - WB_REGWRITE_BIT=0 and WB_MEMTOREG_BIT=1 constants.
  - Payload struct typedef mem_wb_payload_t {alu_result, read_data, write_reg, wb_ctrl}, with default widths.
  - State enum {EMPTY, ONE, FULL}.
- One natural sub-module: mem_wb_sat_cnt, a saturating counter instantiated twice under the macro. The skid logic stays inline.

Test Plan:
- Reset: hold rst_n=0 mid-stream with out_valid=1 -> out_valid=0 and outputs 0 immediately (asynchronous); in_ready=1 after release.
- Streaming: out_ready=1, 4 beats alu=0x10..0x13 back-to-back -> out alu=0x10..0x13 on consecutive cycles starting 1 cycle after the first accept; in_ready stays 1.
- Back-pressure:
  - Stimulus: out_ready=0, send beats A=0xAAAA0000, B=0xBBBB0000, C.
  - Response: A held on the outputs; B lands in the skid; in_ready=0 the cycle after B; C is not accepted.
  - On out_ready=1, the outputs show A, then B, then C (after C is re-presented).
- Flush: FULL state, pulse flush with in_valid=1 -> out_valid=0 next cycle, in_ready=1, flushed beats never appear.
- Forwarding:
  - Beat alu=0x5, read=0x9, reg=3, wb_ctrl=2'b11 -> fwd_valid=1, fwd_reg=3, fwd_data=0x9.
  - Same beat with reg=0, or wb_ctrl=2'b10 -> fwd_valid=0.
- MEM_WB_PERF_EN build with CNT_W=4: 20 cycles of out_valid=1, out_ready=0 -> stall_cnt saturates at 15.
